// File: rtl/byte_striping_ctrl.sv
// rtl/byte_striping_ctrl.sv - round-robin 32-bit word striper for the PHY lane pair
//
// Purpose:
//   Takes one 32-bit word stream and drives the PHY lane pair. After start it
//   runs a link-up SYNC sequence. It then stripes words round-robin onto
//   lane 0 / lane 1, or onto lane 0 only in single-lane mode. A lone half
//   pair is padded out after an idle timeout or on stop.
//
// Optional feature:
//   LANE_SKP_EN - when defined, a skip beat (SKP_WORD on every enabled lane)
//   is inserted after every SKP_INTERVAL emissions in ACTIVE.
//
// Ports:
//   clk_f     in   1   single clock, rising edge
//   reset     in   1   synchronous, active-high
//   start     in   1   in IDLE: latch lane_cfg, enter SYNC
//   stop      in   1   in ACTIVE: flush then return to IDLE
//   lane_cfg  in   1   0 = two lanes, 1 = lane 0 only (sampled with start)
//   data_in   in   32  source word
//   valid_in  in   1   data_in valid
//   ready     out  1   word accepted when valid_in && ready
//   lane_0    out  32  lane 0 data (registered)
//   lane_1    out  32  lane 1 data (registered)
//   valid_0   out  1   lane 0 valid (registered)
//   valid_1   out  1   lane 1 valid (registered)
//   state     out  2   00 IDLE, 01 SYNC, 10 ACTIVE, 11 FLUSH

module byte_striping_ctrl #(
    parameter int unsigned SYNC_CYCLES  = 4,
    parameter logic [31:0] SYNC_WORD    = 32'hBCBCBCBC,
    parameter logic [31:0] PAD_WORD     = 32'h7C7C7C7C,
    parameter int unsigned IDLE_TIMEOUT = 3
`ifdef LANE_SKP_EN
    ,
    parameter int unsigned SKP_INTERVAL = 8,
    parameter logic [31:0] SKP_WORD     = 32'h1C1C1C1C
`endif
) (
    input  logic        clk_f,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        lane_cfg,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready,
    output logic [31:0] lane_0,
    output logic [31:0] lane_1,
    output logic        valid_0,
    output logic        valid_1,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SYNC   = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_FLUSH  = 2'b11
    } state_t;

    // Counters count 0..N-1, so $clog2(N) bits suffice (minimum 1 bit).
    localparam int SW = (SYNC_CYCLES  < 2) ? 1 : $clog2(SYNC_CYCLES);
    localparam int IW = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          mode_q, mode_d;          // 1 = single-lane
    logic [31:0]   hold_q, hold_d;
    logic          half_q, half_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [SW-1:0] sync_q, sync_d;
    logic [15:0]   pair_q, pair_d;

    logic [31:0]   lane_0_d, lane_1_d;
    logic          valid_0_d, valid_1_d;
    logic          emit_data;
    logic          accept;
    logic          skip_beat;

`ifdef LANE_SKP_EN
    localparam int KW = (SKP_INTERVAL < 2) ? 1 : $clog2(SKP_INTERVAL);
    localparam logic [KW-1:0] SKP_LAST = KW'(SKP_INTERVAL - 1);
    logic          skip_pend_q, skip_pend_d;
    logic [KW-1:0] skip_cnt_q, skip_cnt_d;
    assign skip_beat = skip_pend_q;
`else
    assign skip_beat = 1'b0;
`endif

    // Registered state only, so ready never depends on valid_in.
    assign ready  = (state_q == ST_ACTIVE) && !skip_beat;
    assign accept = valid_in && ready;
    assign state  = state_q;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        hold_d    = hold_q;
        half_d    = half_q;
        idle_d    = idle_q;
        sync_d    = sync_q;
        pair_d    = pair_q;
        lane_0_d  = '0;
        lane_1_d  = '0;
        valid_0_d = 1'b0;
        valid_1_d = 1'b0;
        emit_data = 1'b0;
`ifdef LANE_SKP_EN
        skip_pend_d = skip_pend_q;
        skip_cnt_d  = skip_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = lane_cfg;
                    sync_d  = '0;
                    state_d = ST_SYNC;
                end
            end

            ST_SYNC: begin
                lane_0_d  = SYNC_WORD;
                valid_0_d = 1'b1;
                if (!mode_q) begin
                    lane_1_d  = SYNC_WORD;
                    valid_1_d = 1'b1;
                end
                if (sync_q == SYNC_LAST) begin
                    sync_d  = '0;
                    state_d = ST_ACTIVE;
                end else begin
                    sync_d = sync_q + 1'b1;
                end
            end

            ST_ACTIVE: begin
                if (skip_beat) begin
                    // Half pair and idle counter are left untouched here.
`ifdef LANE_SKP_EN
                    lane_0_d  = SKP_WORD;
                    valid_0_d = 1'b1;
                    if (!mode_q) begin
                        lane_1_d  = SKP_WORD;
                        valid_1_d = 1'b1;
                    end
                    skip_pend_d = 1'b0;
`endif
                end else if (mode_q) begin
                    if (accept) begin
                        lane_0_d  = data_in;
                        valid_0_d = 1'b1;
                        emit_data = 1'b1;
                    end
                end else if (accept) begin
                    if (half_q) begin
                        lane_0_d  = hold_q;
                        lane_1_d  = data_in;
                        valid_0_d = 1'b1;
                        valid_1_d = 1'b1;
                        half_d    = 1'b0;
                        emit_data = 1'b1;
                    end else begin
                        hold_d = data_in;
                        half_d = 1'b1;
                    end
                    idle_d = '0;
                end else if (half_q) begin
                    // Timeout cycle: a word arriving now would have taken the
                    // accept branch above, so padding only happens when idle.
                    if (idle_q == IDLE_LAST) begin
                        lane_0_d  = hold_q;
                        lane_1_d  = PAD_WORD;
                        valid_0_d = 1'b1;
                        valid_1_d = 1'b1;
                        half_d    = 1'b0;
                        idle_d    = '0;
                        emit_data = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                // The same-cycle word above is already processed.
                if (stop) begin
                    state_d = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                if (half_q) begin
                    lane_0_d  = hold_q;
                    lane_1_d  = PAD_WORD;
                    valid_0_d = 1'b1;
                    valid_1_d = 1'b1;
                    half_d    = 1'b0;
                    emit_data = 1'b1;
                end
                idle_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (emit_data) begin
            pair_d = pair_q + 16'd1;
        end

`ifdef LANE_SKP_EN
        if ((state_q == ST_ACTIVE) && emit_data) begin
            if (skip_cnt_q == SKP_LAST) begin
                skip_pend_d = 1'b1;
                skip_cnt_d  = '0;
            end else begin
                skip_cnt_d = skip_cnt_q + 1'b1;
            end
        end
        if (state_d != ST_ACTIVE) begin
            skip_pend_d = 1'b0;
            skip_cnt_d  = '0;
        end
`endif
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            hold_q  <= '0;
            half_q  <= 1'b0;
            idle_q  <= '0;
            sync_q  <= '0;
            pair_q  <= '0;
            lane_0  <= '0;
            lane_1  <= '0;
            valid_0 <= 1'b0;
            valid_1 <= 1'b0;
`ifdef LANE_SKP_EN
            skip_pend_q <= 1'b0;
            skip_cnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
            half_q  <= half_d;
            idle_q  <= idle_d;
            sync_q  <= sync_d;
            pair_q  <= pair_d;
            lane_0  <= lane_0_d;
            lane_1  <= lane_1_d;
            valid_0 <= valid_0_d;
            valid_1 <= valid_1_d;
`ifdef LANE_SKP_EN
            skip_pend_q <= skip_pend_d;
            skip_cnt_q  <= skip_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_byte_striping_ctrl.sv
// tb/tb_byte_striping_ctrl.sv - scoreboard testbench for byte_striping_ctrl

module tb_byte_striping_ctrl;

    localparam logic [31:0] SYNC_W = 32'hBCBCBCBC;
    localparam logic [31:0] PAD_W  = 32'h7C7C7C7C;
    localparam logic [31:0] SKP_W  = 32'h1C1C1C1C;

    logic        clk_f = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        lane_cfg;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready;
    logic [31:0] lane_0;
    logic [31:0] lane_1;
    logic        valid_0;
    logic        valid_1;
    logic [1:0]  state;

    typedef struct {
        logic [31:0] l0;
        logic [31:0] l1;
        logic        v1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    byte_striping_ctrl dut (
        .clk_f    (clk_f),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .lane_cfg (lane_cfg),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready),
        .lane_0   (lane_0),
        .lane_1   (lane_1),
        .valid_0  (valid_0),
        .valid_1  (valid_1),
        .state    (state)
    );

    always #5 clk_f = ~clk_f;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic push(input logic [31:0] l0, input logic [31:0] l1, input logic v1);
        exp_t e;
        e.l0 = l0;
        e.l1 = l1;
        e.v1 = v1;
        exp_q.push_back(e);
    endtask

    task automatic push_sync(input logic single);
        for (int i = 0; i < 4; i++) begin
            if (single) push(SYNC_W, 32'h0, 1'b0);
            else        push(SYNC_W, SYNC_W, 1'b1);
        end
    endtask

    task automatic do_start(input logic cfg);
        start    = 1'b1;
        lane_cfg = cfg;
        push_sync(cfg);
        tick();
        start    = 1'b0;
        lane_cfg = ~cfg;
        repeat (4) tick();
        chk("active_state", 32'(state), 32'd2);
        chk("active_ready", 32'(ready), 32'd1);
    endtask

    // Output monitor: every valid beat must match the head of the scoreboard.
    always @(negedge clk_f) begin
        exp_t e;
        if (mon_en) begin
            if (valid_0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_emit", 32'(valid_0), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("lane_0", lane_0, e.l0);
                    chk("lane_1", lane_1, e.l1);
                    chk("valid_1", 32'(valid_1), 32'(e.v1));
                end
            end else begin
                chk("idle_lane_0", lane_0, 32'h0);
                chk("idle_lane_1", lane_1, 32'h0);
                chk("idle_valid_1", 32'(valid_1), 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] prev;
        logic [31:0] w;
        int          pairs;
        int          low_cnt;
        int          guard;

        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        lane_cfg = 1'b0;
        data_in  = '0;
        valid_in = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_valid_0", 32'(valid_0), 32'd0);
        chk("rst_valid_1", 32'(valid_1), 32'd0);
        chk("rst_lane_0", lane_0, 32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        // Two-lane sync, then a back-to-back pair.
        do_start(1'b0);
        valid_in = 1'b1;
        data_in  = 32'h11111111;
        tick();
        data_in  = 32'h22222222;
        push(32'h11111111, 32'h22222222, 1'b1);
        tick();
        valid_in = 1'b0;
        tick();

        // Half pair padded after three idle cycles.
        valid_in = 1'b1;
        data_in  = 32'hAAAAAAAA;
        push(32'hAAAAAAAA, PAD_W, 1'b1);
        tick();
        valid_in = 1'b0;
        repeat (4) tick();

        // Word arriving on the timeout cycle pairs normally.
        valid_in = 1'b1;
        data_in  = 32'hBBBBBBBB;
        tick();
        valid_in = 1'b0;
        repeat (2) tick();
        valid_in = 1'b1;
        data_in  = 32'hCCCCCCCC;
        push(32'hBBBBBBBB, 32'hCCCCCCCC, 1'b1);
        tick();
        valid_in = 1'b0;
        repeat (4) tick();
        chk("no_stray_pad", 32'(exp_q.size()), 32'd0);

        // Stop with nothing pending.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk("stop_idle_state", 32'(state), 32'd0);

        // Single-lane.
        do_start(1'b1);
        for (int i = 1; i <= 3; i++) begin
            valid_in = 1'b1;
            data_in  = 32'(i);
            push(32'(i), 32'h0, 1'b0);
            tick();
        end
        valid_in = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk("single_idle_state", 32'(state), 32'd0);

        // Accept a word together with stop: flush pads it.
        do_start(1'b0);
        valid_in = 1'b1;
        data_in  = 32'h55555555;
        stop     = 1'b1;
        push(32'h55555555, PAD_W, 1'b1);
        tick();
        valid_in = 1'b0;
        stop     = 1'b0;
        tick();
        chk("flush_state", 32'(state), 32'd0);
        chk("flush_ready", 32'(ready), 32'd0);
        tick();

        // Reset mid-pair drops the half pair.
        do_start(1'b0);
        valid_in = 1'b1;
        data_in  = 32'h66666666;
        tick();
        valid_in = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_valid_0", 32'(valid_0), 32'd0);
        chk("midrst_lane_0", lane_0, 32'h0);
        repeat (5) tick();
        chk("midrst_quiet", 32'(exp_q.size()), 32'd0);

        // Stream 18 words two-lane; skip beat after the 8th pair when enabled.
        do_start(1'b0);
        pairs   = 0;
        low_cnt = 0;
        prev    = '0;
        for (int i = 0; i < 18; i++) begin
            w        = 32'hD0000000 + 32'(i);
            valid_in = 1'b1;
            data_in  = w;
            guard    = 0;
            while (!ready && guard < 10) begin
                low_cnt++;
                guard++;
                tick();
            end
            if (guard >= 10) begin
                chk("ready_timeout", 32'(ready), 32'd1);
            end
            if (i % 2 == 1) begin
                push(prev, w, 1'b1);
                pairs++;
`ifdef LANE_SKP_EN
                if (pairs == 8) push(SKP_W, SKP_W, 1'b1);
`endif
            end
            prev = w;
            tick();
        end
        valid_in = 1'b0;
        repeat (4) tick();
`ifdef LANE_SKP_EN
        chk("skip_ready_low", 32'(low_cnt), 32'd1);
`else
        chk("skip_ready_low", 32'(low_cnt), 32'd0);
`endif
        chk("stream_pairs", 32'(pairs), 32'd9);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
